// File: rtl/operand_skew_feeder.sv
// operand_skew_feeder: sequences the A/B operand banks through their send mode,
// captures one bus word per cycle from each, and re-emits every lane with a
// diagonal delay (lane i delayed i extra cycles) to build the skewed wavefront
// consumed by the processing-element array. Non-valid slots always carry zeros.
module operand_skew_feeder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BUS_WIDTH  = 64,
  localparam int unsigned MAX_DIM   = BUS_WIDTH / DATA_WIDTH,
  localparam int unsigned KW        = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [KW-1:0]        k_dim_i,
  input  logic [BUS_WIDTH-1:0] a_data_i,
  input  logic [BUS_WIDTH-1:0] b_data_i,
  output logic                 start_send_o,
  output logic [BUS_WIDTH-1:0] a_skew_o,
  output logic [BUS_WIDTH-1:0] b_skew_o,
  output logic [MAX_DIM-1:0]   a_valid_o,
  output logic [MAX_DIM-1:0]   b_valid_o,
  output logic                 valid_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StDone
  } state_e;

  state_e          state_q, state_d;
  // Shared cycle counter: word index in FETCH, drain step in DRAIN.
  logic [KW-1:0]   cnt_q, cnt_d;
  // Inner dimension minus one, frozen for the duration of a feed.
  logic [KW-1:0]   k_q, k_d;
  logic            fetch_en;

  // State, counter and latched K registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
    end
  end

  // Next-state logic: IDLE -> FETCH (K cycles) -> DRAIN (MAX_DIM cycles) -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StFetch;
          k_d     = k_dim_i;
          cnt_d   = '0;
        end
      end
      StFetch: begin
        if (cnt_q == k_q) begin
          state_d = StDrain;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (cnt_q == KW'(MAX_DIM - 1)) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control outputs decoded straight from the state so they fall at the reset edge.
  always_comb begin
    fetch_en     = (state_q == StFetch);
    start_send_o = fetch_en;
    busy_o       = (state_q != StIdle);
    done_o       = (state_q == StDone);
  end

  // One delay line per lane; lane gi has gi+1 stages of data plus a valid bit.
  for (genvar gi = 0; gi < MAX_DIM; gi++) begin : g_lane
    localparam int unsigned Depth = gi + 1;
    localparam int unsigned Last  = gi;

    logic [DATA_WIDTH-1:0] a_pipe_q [Depth];
    logic [DATA_WIDTH-1:0] a_pipe_d [Depth];
    logic [DATA_WIDTH-1:0] b_pipe_q [Depth];
    logic [DATA_WIDTH-1:0] b_pipe_d [Depth];
    logic [Depth-1:0]      vld_q, vld_d;

    // Stage 0 loads the bank word only during FETCH, zeros otherwise; later stages shift.
    always_comb begin
      vld_d[0]    = fetch_en;
      a_pipe_d[0] = fetch_en ? a_data_i[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
      b_pipe_d[0] = fetch_en ? b_data_i[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
      for (int s = 1; s < int'(Depth); s++) begin
        vld_d[s]    = vld_q[s-1];
        a_pipe_d[s] = a_pipe_q[s-1];
        b_pipe_d[s] = b_pipe_q[s-1];
      end
    end

    // Delay-line registers, cleared on reset so no stale word survives an abort.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        vld_q <= '0;
        for (int s = 0; s < int'(Depth); s++) begin
          a_pipe_q[s] <= '0;
          b_pipe_q[s] <= '0;
        end
      end else begin
        vld_q <= vld_d;
        for (int s = 0; s < int'(Depth); s++) begin
          a_pipe_q[s] <= a_pipe_d[s];
          b_pipe_q[s] <= b_pipe_d[s];
        end
      end
    end

    // Last stage drives the lane; data is masked by valid as a second guard against garbage.
    assign a_valid_o[gi] = vld_q[Last];
    assign b_valid_o[gi] = vld_q[Last];
    assign a_skew_o[gi*DATA_WIDTH +: DATA_WIDTH] = vld_q[Last] ? a_pipe_q[Last] : '0;
    assign b_skew_o[gi*DATA_WIDTH +: DATA_WIDTH] = vld_q[Last] ? b_pipe_q[Last] : '0;
  end

  // Any lane carrying data makes the wavefront valid.
  always_comb begin
    valid_o = |a_valid_o;
  end

endmodule

// File: tb/tb_operand_skew_feeder.sv
// Scoreboard bench for operand_skew_feeder: the driver pushes expected lane
// words (with their cycle) and expected control levels; a negedge monitor
// compares whatever the DUT presents each cycle.
module tb_operand_skew_feeder;

  localparam int DW = 32;
  localparam int BW = 64;
  localparam int MD = 2;
  localparam logic [BW-1:0] GARB_A = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [BW-1:0] GARB_B = 64'h0BAD_F00D_1234_5678;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [0:0]    k_dim;
  logic [BW-1:0] a_data, b_data;
  logic          start_send;
  logic [BW-1:0] a_skew, b_skew;
  logic [MD-1:0] a_valid, b_valid;
  logic          valid_o, busy, done;

  operand_skew_feeder #(
    .DATA_WIDTH(DW),
    .BUS_WIDTH (BW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .k_dim_i     (k_dim),
    .a_data_i    (a_data),
    .b_data_i    (b_data),
    .start_send_o(start_send),
    .a_skew_o    (a_skew),
    .b_skew_o    (b_skew),
    .a_valid_o   (a_valid),
    .b_valid_o   (b_valid),
    .valid_o     (valid_o),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Operand bank model: send address advances while start_send is high, else returns to 0.
  logic [BW-1:0] a_mem [2];
  logic [BW-1:0] b_mem [2];
  int addr = 0;
  always @(posedge clk) addr <= start_send ? addr + 1 : 0;
  always_comb begin
    a_data = GARB_A;
    b_data = GARB_B;
    if (start_send === 1'b1 && addr < 2) begin
      a_data = a_mem[addr];
      b_data = b_mem[addr];
    end
  end

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t lq0[$];
  exp_t lq1[$];
  bit   exp_send [4096];
  bit   exp_busy [4096];
  bit   exp_done [4096];

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s in cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endfunction

  function automatic void push_exp(int lane, int c, logic [31:0] a, logic [31:0] b);
    exp_t e;
    e.cyc = c;
    e.a   = a;
    e.b   = b;
    if (lane == 0) lq0.push_back(e);
    else           lq1.push_back(e);
  endfunction

  // Control expectations for a feed accepted in cycle c0.
  function automatic void sched_ctrl(int c0, int k);
    int kk = k + 1;
    for (int c = c0 + 1; c <= c0 + kk; c++) exp_send[c] = 1'b1;
    for (int c = c0 + 1; c <= c0 + kk + MD + 1; c++) exp_busy[c] = 1'b1;
    exp_done[c0 + kk + MD + 1] = 1'b1;
  endfunction

  // Lane i of word j appears in cycle c0+j+2+i.
  function automatic void sched_data(int c0, int k);
    for (int j = 0; j <= k; j++)
      for (int i = 0; i < MD; i++)
        push_exp(i, c0 + j + 2 + i, a_mem[j][i*DW +: DW], b_mem[j][i*DW +: DW]);
  endfunction

  // Drop every expectation from cycle 'from' onwards (aborted feed).
  task automatic prune(int from);
    exp_t t0[$];
    exp_t t1[$];
    foreach (lq0[n]) if (lq0[n].cyc < from) t0.push_back(lq0[n]);
    foreach (lq1[n]) if (lq1[n].cyc < from) t1.push_back(lq1[n]);
    lq0 = t0;
    lq1 = t1;
    for (int c = from; c < from + 32; c++) begin
      exp_send[c] = 1'b0;
      exp_busy[c] = 1'b0;
      exp_done[c] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one feed and wait until the earliest cycle a new start is accepted.
  task automatic run_feed(input logic k, input logic [BW-1:0] a0, input logic [BW-1:0] a1,
                          input logic [BW-1:0] b0, input logic [BW-1:0] b1,
                          input bit use_formula, output int c0);
    a_mem[0] = a0;
    a_mem[1] = a1;
    b_mem[0] = b0;
    b_mem[1] = b1;
    start    = 1'b1;
    k_dim    = k;
    c0       = cyc;
    sched_ctrl(c0, int'(k));
    if (use_formula) sched_data(c0, int'(k));
    tick();
    start = 1'b0;
    k_dim = ~k;  // later changes must not affect the running feed
    repeat (int'(k) + 1 + MD + 1) tick();
  endtask

  logic [MD-1:0] exp_v;
  bit            mon_ev;
  exp_t          mon_e;

  // Monitor: every cycle, compare lanes against the scoreboard and controls against expectations.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_v = '0;
      for (int i = 0; i < MD; i++) begin
        mon_ev = 1'b0;
        if (i == 0) begin
          while (lq0.size() > 0 && lq0[0].cyc < cyc) lq0.delete(0);
          if (lq0.size() > 0 && lq0[0].cyc == cyc) begin
            mon_ev = 1'b1;
            mon_e  = lq0.pop_front();
          end
        end else begin
          while (lq1.size() > 0 && lq1[0].cyc < cyc) lq1.delete(0);
          if (lq1.size() > 0 && lq1[0].cyc == cyc) begin
            mon_ev = 1'b1;
            mon_e  = lq1.pop_front();
          end
        end
        exp_v[i] = mon_ev;
        check($sformatf("a_valid[%0d]", i), 64'(a_valid[i]), 64'(mon_ev));
        check($sformatf("b_valid[%0d]", i), 64'(b_valid[i]), 64'(mon_ev));
        if (mon_ev) begin
          check($sformatf("a_lane%0d", i), 64'(a_skew[i*DW +: DW]), 64'(mon_e.a));
          check($sformatf("b_lane%0d", i), 64'(b_skew[i*DW +: DW]), 64'(mon_e.b));
        end else begin
          check($sformatf("a_lane%0d_zero", i), 64'(a_skew[i*DW +: DW]), 64'd0);
          check($sformatf("b_lane%0d_zero", i), 64'(b_skew[i*DW +: DW]), 64'd0);
        end
      end
      check("valid_o", 64'(valid_o), 64'(|exp_v));
      check("start_send", 64'(start_send), 64'(exp_send[cyc]));
      check("busy", 64'(busy), 64'(exp_busy[cyc]));
      check("done", 64'(done), 64'(exp_done[cyc]));
    end
  end

  initial begin
    int c0;
    rst   = 1'b1;
    start = 1'b0;
    k_dim = '0;
    a_mem[0] = '0;
    a_mem[1] = '0;
    b_mem[0] = '0;
    b_mem[1] = '0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;  // reset has been applied once; reset values are checked from here
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // K=2 directed: hand-computed lane values and cycles.
    c0 = cyc;
    a_mem[0] = 64'h00000002_00000001;
    a_mem[1] = 64'h00000004_00000003;
    b_mem[0] = 64'h000000B2_000000B1;
    b_mem[1] = 64'h000000B4_000000B3;
    push_exp(0, c0 + 2, 32'h1, 32'hB1);
    push_exp(0, c0 + 3, 32'h3, 32'hB3);
    push_exp(1, c0 + 3, 32'h2, 32'hB2);
    push_exp(1, c0 + 4, 32'h4, 32'hB4);
    run_feed(1'b1, a_mem[0], a_mem[1], b_mem[0], b_mem[1], 1'b0, c0);

    // K=1 directed.
    c0 = cyc;
    push_exp(0, c0 + 2, 32'h11111111, 32'h0000000A);
    push_exp(1, c0 + 3, 32'h22222222, 32'h0000000B);
    run_feed(1'b0, 64'h22222222_11111111, 64'h0, 64'h0000000B_0000000A, 64'h0,
             1'b0, c0);
    repeat (2) tick();

    // start held high: only one feed, next accepted at cycle c0+6.
    a_mem[0] = 64'h0A0A0A0A_05050505;
    a_mem[1] = 64'h0B0B0B0B_06060606;
    b_mem[0] = 64'h0C0C0C0C_07070707;
    b_mem[1] = 64'h0D0D0D0D_08080808;
    c0    = cyc;
    start = 1'b1;
    k_dim = 1'b1;
    sched_ctrl(c0, 1);
    sched_data(c0, 1);
    sched_ctrl(c0 + 6, 1);
    sched_data(c0 + 6, 1);
    repeat (7) tick();
    start = 1'b0;
    repeat (5) tick();
    repeat (2) tick();

    // Reset in cycle 2 of a K=2 feed, then reset and start together.
    c0    = cyc;
    start = 1'b1;
    k_dim = 1'b1;
    sched_ctrl(c0, 1);
    sched_data(c0, 1);
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    prune(c0 + 3);
    tick();
    rst   = 1'b0;
    tick();
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    repeat (4) tick();

    // Random back-to-back feeds alternating K.
    for (int n = 0; n < 8; n++) begin
      run_feed(logic'(n[0] ^ n[2]), {$urandom, $urandom}, {$urandom, $urandom},
               {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, c0);
    end
    repeat (4) tick();

    check("lane0_leftover", 64'(lq0.size()), 64'd0);
    check("lane1_leftover", 64'(lq1.size()), 64'd0);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/operand_skew_feeder.md
# operand_skew_feeder

Downstream consumer of the two operand register banks (matrix A and matrix B) in the matrix-multiply accelerator. On a start pulse it sequences both banks through their send mode and captures one bus word per cycle from each. It re-emits every DATA_WIDTH lane with a per-lane diagonal delay: lane i is delayed i cycles. This skewed wavefront feeds the processing-element array, with zeros in every non-valid slot.

## Interface
- DATA_WIDTH, 32, element width in bits
- BUS_WIDTH, 64, operand word width; localparam MAX_DIM = BUS_WIDTH/DATA_WIDTH lanes
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  begin a feed; sampled only in IDLE
- k_dim_i  in  $clog2(MAX_DIM)  inner dimension minus one (K = k_dim_i+1 words); captured with start_i
- a_data_i  in  BUS_WIDTH  word from A operand bank (combinational read, current send address)
- b_data_i  in  BUS_WIDTH  word from B operand bank
- start_send_o  out  1  drives start_send_i of both banks; high exactly during FETCH
- a_skew_o  out  BUS_WIDTH  skewed A lanes; lane i = bits [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
- b_skew_o  out  BUS_WIDTH  skewed B lanes, same mapping
- a_valid_o  out  MAX_DIM  per-lane valid for a_skew_o
- b_valid_o  out  MAX_DIM  per-lane valid for b_skew_o (always equal to a_valid_o)
- valid_o  out  1  OR of a_valid_o
- busy_o  out  1  high whenever state != IDLE; upstream blocks operand writes (strobes) while high
- done_o  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, FETCH, DRAIN, DONE.
  - IDLE -> FETCH when start_i=1. Latch K.
  - FETCH lasts K cycles. start_send_o=1. Banks present word 0, 1, …, K-1 on consecutive cycles. Word j is sampled at the end of FETCH cycle j.
  - FETCH -> DRAIN after the K-th cycle. DRAIN lasts MAX_DIM cycles.
  - DRAIN -> DONE. done_o=1 for one cycle. DONE -> IDLE unconditionally.
- Each lane i has a delay line of depth i+1 carrying data and a valid bit. Stage 0 loads a_data_i/b_data_i lane i with valid=1 during FETCH, and zero data with valid=0 otherwise.
- Skew outputs are the last stage of each line.
- A lane whose valid is 0 outputs all-zero data. Garbage is never forwarded.
- A and B use identical timing. No arithmetic is performed and data passes bit-exact.
- start_i outside IDLE (FETCH, DRAIN, DONE) is ignored. There is no queuing.
- k_dim_i changes after the start cycle have no effect on the running feed.
- The block never relies on the bank's internal wrap. start_send_o falls after exactly K cycles, which also resets the bank send address.

## Timing
- Cycle 0 is the cycle with start_i=1 in IDLE.
- FETCH occupies cycles 1..K; start_send_o=1 there.
- Lane i of word j appears on the skew outputs in cycle j+2+i.
- valid_o is high in cycles 2..K+MAX_DIM; DRAIN occupies K+1..K+MAX_DIM.
- done_o=1 in cycle K+MAX_DIM+1.
- busy_o is high in cycles 1..K+MAX_DIM+1. A new start is accepted in cycle K+MAX_DIM+2 at the earliest.
- Reset values: state IDLE, all delay stages zero, all valids 0, start_send_o=0, busy_o=0, done_o=0, all skew outputs 0.
- rst_i mid-operation (any state):
  - next cycle is IDLE with all reset values;
  - start_send_o drops immediately at that edge;
  - no done_o is issued for the aborted feed.
- rst_i and start_i in the same cycle: reset wins and the start is lost.

## Test plan
- MAX_DIM=2, k_dim_i=1, A words 0x00000002_00000001 then 0x00000004_00000003 -> a_skew_o lane0 = 1 in cycle 2 and 3 in cycle 3; lane1 = 2 in cycle 3 and 4 in cycle 4. valid_o in cycles 2–4, done_o in cycle 5, start_send_o in cycles 1–2.
- k_dim_i=0, B word 0x0000000B_0000000A -> lane0 = 0xA in cycle 2, lane1 = 0xB in cycle 3. Lanes are zero with valid 0 elsewhere; done_o in cycle 4.
- start_i held high continuously for K=2 -> only one feed; the second feed begins from the start sampled in cycle 6, so start_send_o rises again in cycle 7.
- rst_i asserted in cycle 2 of a K=2 feed -> cycle 3 shows busy_o=0, start_send_o=0, skew outputs 0; done_o never pulses.
- Random A/B words, both K values, back-to-back feeds -> scoreboard matches the per-lane skew formula. a_valid_o==b_valid_o always, and data is zero whenever the lane valid is 0.
